// File: rtl/wb_mem_checker_pkg.sv
// Shared constants for the Wishbone memory checker: FSM states, LFSR taps,
// Wishbone cycle-type / burst-type codes and the LFSR step helpers.
package wb_mem_checker_pkg;

    // FSM state encoding
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WRITE = 2'd1;
    localparam logic [1:0] S_READ  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    // Galois LFSR feedback mask
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    // Wishbone registered-feedback codes
    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;
    localparam logic [1:0] BTE_LINEAR  = 2'b00;

    // One Galois step: shift right, fold the taps in when the bit shifted out is 1
    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

    // An all-zero seed would lock the LFSR, so it is replaced by 1
    function automatic logic [31:0] seed_fix(input logic [31:0] s);
        return (s == 32'h0) ? 32'h1 : s;
    endfunction

endpackage

// File: rtl/wb_mem_checker_lfsr.sv
// 32-bit Galois LFSR used as the test-pattern generator.
// o_next_c exposes the value the register takes at the next edge so that
// the caller can register it alongside the LFSR without a cycle of lag.
module wb_lfsr32
    import wb_mem_checker_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_load,
    input  logic        i_step,
    input  logic [31:0] i_seed,
    output logic [31:0] o_state,
    output logic [31:0] o_next_c
);

    logic [31:0] r_state;
    logic [31:0] w_next;

    // Next value: load has priority over step
    always_comb begin
        w_next = r_state;
        if (i_load) begin
            w_next = i_seed;
        end else if (i_step) begin
            w_next = lfsr_step(r_state);
        end
    end

    // LFSR register
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= 32'h0;
        end else begin
            r_state <= w_next;
        end
    end

    assign o_state  = r_state;
    assign o_next_c = w_next;

endmodule

// File: rtl/wb_mem_checker.sv
// Wishbone B3 memory checker: writes an LFSR pattern to WORDS words starting
// at BASE_ADR, reads it back and counts miscompares. One beat outstanding.
// Optional feature macro: WB_MEM_CHECKER_BURST_EN -- each phase is issued as
// a single incrementing burst (cyc/stb held, cti 010 ... 111). Without it,
// classic cycles with a one-cycle stb gap between beats.
module wb_mem_checker
    import wb_mem_checker_pkg::*;
#(
    parameter int unsigned WORDS    = 256,
    parameter logic [31:0] BASE_ADR = 32'h0,
    parameter logic [31:0] SEED     = 32'hACE1_2345,
    parameter int unsigned TIMEOUT  = 64
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n_i,
    input  logic        start_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        pass_o,
    output logic [15:0] err_cnt_o,
    output logic [31:0] err_adr_o,
    output logic        timeout_o,
    output logic        bus_err_o,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    output logic        wb_we_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic [2:0]  wb_cti_o,
    output logic [1:0]  wb_bte_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i
);

    localparam int unsigned IDX_W    = 16;
    localparam int unsigned TO_W     = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [31:0] SEED_EFF = seed_fix(SEED);
`ifdef WB_MEM_CHECKER_BURST_EN
    localparam logic        BURST    = 1'b1;
`else
    localparam logic        BURST    = 1'b0;
`endif

    // Registered state and outputs
    logic [1:0]       r_state;
    logic [IDX_W-1:0] r_idx;
    logic [TO_W-1:0]  r_to_cnt;
    logic [31:0]      r_adr, r_dat, r_err_adr;
    logic [3:0]       r_sel;
    logic [2:0]       r_cti;
    logic [15:0]      r_err_cnt;
    logic             r_we, r_cyc, r_stb, r_busy, r_done, r_pass, r_timeout, r_bus_err;

    // Next-state values
    logic [1:0]       w_state_nxt;
    logic [IDX_W-1:0] w_idx_nxt, w_idx_inc;
    logic [TO_W-1:0]  w_to_cnt_nxt;
    logic [31:0]      w_adr_nxt, w_dat_nxt, w_err_adr_nxt;
    logic [3:0]       w_sel_nxt;
    logic [2:0]       w_cti_nxt, w_cti_first, w_cti_step;
    logic [15:0]      w_err_cnt_nxt;
    logic             w_we_nxt, w_cyc_nxt, w_stb_nxt, w_busy_nxt, w_done_nxt, w_pass_nxt;
    logic             w_timeout_nxt, w_bus_err_nxt, w_finish;

    // Bus handshake qualifiers; err wins over a simultaneous ack
    logic             w_beat_ack, w_beat_err, w_last;
    logic             w_lfsr_load, w_lfsr_step;
    logic [31:0]      w_lfsr_state, w_lfsr_next;

    assign w_beat_err = r_stb & wb_err_i;
    assign w_beat_ack = r_stb & wb_ack_i & ~wb_err_i;
    assign w_last     = (r_idx == IDX_W'(WORDS - 1));
    assign w_idx_inc  = r_idx + IDX_W'(1);

`ifdef WB_MEM_CHECKER_BURST_EN
    assign w_cti_first = (WORDS == 1) ? CTI_EOB : CTI_INCR;
    assign w_cti_step  = (w_idx_inc == IDX_W'(WORDS - 1)) ? CTI_EOB : CTI_INCR;
`else
    assign w_cti_first = CTI_CLASSIC;
    assign w_cti_step  = CTI_CLASSIC;
`endif

    // Pattern generator
    wb_lfsr32 u_lfsr (
        .i_clk    (wb_clk_i),
        .i_rst_n  (wb_rst_n_i),
        .i_load   (w_lfsr_load),
        .i_step   (w_lfsr_step),
        .i_seed   (SEED_EFF),
        .o_state  (w_lfsr_state),
        .o_next_c (w_lfsr_next)
    );

    // Next-state and output decode
    always_comb begin
        w_state_nxt   = r_state;
        w_idx_nxt     = r_idx;
        w_to_cnt_nxt  = '0;
        w_adr_nxt     = r_adr;
        w_sel_nxt     = r_sel;
        w_cti_nxt     = r_cti;
        w_we_nxt      = r_we;
        w_cyc_nxt     = r_cyc;
        w_stb_nxt     = r_stb;
        w_busy_nxt    = r_busy;
        w_done_nxt    = r_done;
        w_pass_nxt    = r_pass;
        w_err_cnt_nxt = r_err_cnt;
        w_err_adr_nxt = r_err_adr;
        w_timeout_nxt = r_timeout;
        w_bus_err_nxt = r_bus_err;
        w_lfsr_load   = 1'b0;
        w_lfsr_step   = 1'b0;
        w_finish      = 1'b0;

        case (r_state)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    w_state_nxt   = S_WRITE;
                    w_idx_nxt     = '0;
                    w_lfsr_load   = 1'b1;
                    w_adr_nxt     = BASE_ADR;
                    w_sel_nxt     = 4'hF;
                    w_cti_nxt     = w_cti_first;
                    w_we_nxt      = 1'b1;
                    w_cyc_nxt     = 1'b1;
                    w_stb_nxt     = 1'b1;
                    w_busy_nxt    = 1'b1;
                    w_done_nxt    = 1'b0;
                    w_pass_nxt    = 1'b0;
                    w_err_cnt_nxt = 16'h0;
                    w_err_adr_nxt = 32'h0;
                    w_timeout_nxt = 1'b0;
                    w_bus_err_nxt = 1'b0;
                end
            end
            S_WRITE, S_READ: begin
                if (w_beat_err) begin
                    w_bus_err_nxt = 1'b1;
                    w_finish      = 1'b1;
                end else if (w_beat_ack) begin
                    w_lfsr_step = 1'b1;
                    if ((r_state == S_READ) && (wb_dat_i != w_lfsr_state)) begin
                        if (r_err_cnt != 16'hFFFF) begin
                            w_err_cnt_nxt = r_err_cnt + 16'd1;
                        end
                        if (r_err_cnt == 16'h0) begin
                            w_err_adr_nxt = r_adr;
                        end
                    end
                    if (w_last) begin
                        if (r_state == S_WRITE) begin
                            // One idle cycle on the bus, then the read phase from word 0
                            w_state_nxt = S_READ;
                            w_lfsr_load = 1'b1;
                            w_idx_nxt   = '0;
                            w_adr_nxt   = BASE_ADR;
                            w_cti_nxt   = CTI_CLASSIC;
                            w_we_nxt    = 1'b0;
                            w_cyc_nxt   = 1'b0;
                            w_stb_nxt   = 1'b0;
                        end else begin
                            w_finish = 1'b1;
                        end
                    end else begin
                        w_idx_nxt = w_idx_inc;
                        w_adr_nxt = r_adr + 32'd4;
                        w_cti_nxt = w_cti_step;
                        w_stb_nxt = BURST;
                    end
                end else if (r_stb) begin
                    if (r_to_cnt == TO_W'(TIMEOUT - 1)) begin
                        w_timeout_nxt = 1'b1;
                        w_finish      = 1'b1;
                    end else begin
                        w_to_cnt_nxt = r_to_cnt + TO_W'(1);
                    end
                end else begin
                    // Gap cycle over: present the current beat
                    w_cyc_nxt = 1'b1;
                    w_stb_nxt = 1'b1;
                    w_cti_nxt = (r_idx == '0) ? w_cti_first : w_cti_step;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        if (w_finish) begin
            w_state_nxt = S_DONE;
            w_cyc_nxt   = 1'b0;
            w_stb_nxt   = 1'b0;
            w_we_nxt    = 1'b0;
            w_sel_nxt   = 4'h0;
            w_cti_nxt   = CTI_CLASSIC;
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
            w_pass_nxt  = (w_err_cnt_nxt == 16'h0) && !w_timeout_nxt && !w_bus_err_nxt;
        end

        w_dat_nxt = (w_state_nxt == S_WRITE) ? w_lfsr_next : 32'h0;
    end

    // State and output registers
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i) begin
            r_state   <= S_IDLE;
            r_idx     <= '0;
            r_to_cnt  <= '0;
            r_adr     <= 32'h0;
            r_dat     <= 32'h0;
            r_sel     <= 4'h0;
            r_cti     <= CTI_CLASSIC;
            r_we      <= 1'b0;
            r_cyc     <= 1'b0;
            r_stb     <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_pass    <= 1'b0;
            r_err_cnt <= 16'h0;
            r_err_adr <= 32'h0;
            r_timeout <= 1'b0;
            r_bus_err <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_idx     <= w_idx_nxt;
            r_to_cnt  <= w_to_cnt_nxt;
            r_adr     <= w_adr_nxt;
            r_dat     <= w_dat_nxt;
            r_sel     <= w_sel_nxt;
            r_cti     <= w_cti_nxt;
            r_we      <= w_we_nxt;
            r_cyc     <= w_cyc_nxt;
            r_stb     <= w_stb_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_pass    <= w_pass_nxt;
            r_err_cnt <= w_err_cnt_nxt;
            r_err_adr <= w_err_adr_nxt;
            r_timeout <= w_timeout_nxt;
            r_bus_err <= w_bus_err_nxt;
        end
    end

    assign busy_o    = r_busy;
    assign done_o    = r_done;
    assign pass_o    = r_pass;
    assign err_cnt_o = r_err_cnt;
    assign err_adr_o = r_err_adr;
    assign timeout_o = r_timeout;
    assign bus_err_o = r_bus_err;
    assign wb_adr_o  = r_adr;
    assign wb_dat_o  = r_dat;
    assign wb_sel_o  = r_sel;
    assign wb_we_o   = r_we;
    assign wb_cyc_o  = r_cyc;
    assign wb_stb_o  = r_stb;
    assign wb_cti_o  = r_cti;
    assign wb_bte_o  = BTE_LINEAR;

endmodule

// File: doc/wb_mem_checker.md
WB_MEM_CHECKER -- requirements
Module: wb_mem_checker

Interface
REQ-001 SHALL have parameter WORDS, default 256: number of 32-bit words tested (1..65535).
REQ-002 SHALL have parameter BASE_ADR, default 32'h0: byte address of first word, 4-byte aligned.
REQ-003 SHALL have parameter SEED, default 32'hACE1_2345: LFSR seed; 0 is replaced by 32'h1.
REQ-004 SHALL have parameter TIMEOUT, default 64: maximum cycles to wait for ack per beat.
REQ-005 SHALL have ports: wb_clk_i in 1 clock; wb_rst_n_i in 1 synchronous active-low reset.
REQ-006 SHALL have ports: start_i in 1 run request pulse; busy_o out 1 run active; done_o out 1 run finished (sticky); pass_o out 1 no errors (valid when done_o).
REQ-007 SHALL have ports: err_cnt_o out 16 miscompare count, saturating; err_adr_o out 32 first failing byte address; timeout_o out 1 aborted on missing ack; bus_err_o out 1 aborted on wb_err_i.
REQ-008 SHALL have Wishbone master ports: wb_adr_o 32, wb_dat_o 32, wb_sel_o 4, wb_we_o 1, wb_cyc_o 1, wb_stb_o 1, wb_cti_o 3, wb_bte_o 2 (out); wb_dat_i 32, wb_ack_i 1, wb_err_i 1 (in).

Function
REQ-009 SHALL sit upstream of wb_ram, driving classic Wishbone B3 transfers, one outstanding beat.
REQ-010 SHALL implement FSM IDLE -> WRITE -> READ -> DONE; DONE -> WRITE on start_i; abort from WRITE/READ -> DONE.
REQ-011 SHALL accept start_i only in IDLE or DONE; ignored while busy_o=1.
REQ-012 SHALL on start clear done_o, err_cnt_o, err_adr_o, timeout_o, bus_err_o; load LFSR with SEED; set index 0.
REQ-013 SHALL generate data with 32-bit Galois LFSR, taps 32'h8020_0003, one step per accepted beat; word i = state after i steps.
REQ-014 SHALL in WRITE assert cyc/stb/we=1, sel=4'hF, adr=BASE_ADR+4*i, dat=LFSR; advance i on ack.
REQ-015 SHALL after last write ack reload LFSR with SEED, set i=0, deassert cyc/stb for exactly one cycle, enter READ.
REQ-016 SHALL in READ assert cyc/stb=1, we=0, sel=4'hF; on ack compare wb_dat_i with LFSR.
REQ-017 SHALL on miscompare increment err_cnt_o (saturate 16'hFFFF) and latch err_adr_o only on first miscompare.
REQ-018 SHALL after last read ack enter DONE: done_o=1, busy_o=0, cyc/stb=0, pass_o=(err_cnt_o==0)&&!timeout_o&&!bus_err_o.
REQ-019 SHALL count cycles with stb high and no ack; on reaching TIMEOUT set timeout_o, drop cyc/stb next cycle, enter DONE.
REQ-020 SHALL on wb_err_i with stb high set bus_err_o, abort to DONE; wb_err_i takes priority over simultaneous wb_ack_i.
REQ-021 SHALL ignore ack/err while stb low.
REQ-022 SHALL drive wb_cti_o=3'b000, wb_bte_o=2'b00 when burst feature absent.

Reset
REQ-023 SHALL on wb_rst_n_i=0 at clock edge enter IDLE; all outputs 0 (adr, dat, sel, cti, bte, cyc, stb, we, busy, done, pass, err_cnt, err_adr, timeout_o, bus_err_o).
REQ-024 SHALL on reset mid-run drop cyc/stb the same edge, no completion reported.

Configuration
REQ-025 SHALL with WB_MEM_CHECKER_BURST_EN defined issue each phase as one incrementing burst: cyc held, cti=3'b010 on beats 0..WORDS-2, cti=3'b111 on last beat, bte=2'b00, adr advanced on ack.
REQ-026 SHALL without WB_MEM_CHECKER_BURST_EN drop stb for one cycle between beats (cyc may stay high), cti=3'b000.

Structure
REQ-027 SHALL place FSM state enum, LFSR taps constant, CTI/BTE code constants in package wb_mem_checker_pkg.
REQ-028 SHALL implement LFSR as sub-module wb_lfsr32 (load, step, seed, state).

Verification
REQ-029 Reset+start with wb_ram depth 1024, WORDS=256 -> done_o=1, pass_o=1, err_cnt_o=0; word 0 written = 32'hACE1_2345.
REQ-030 Force wb_dat_i bit 0 inverted on read beats 5 and 9 -> err_cnt_o=2, err_adr_o=32'h14, pass_o=0.
REQ-031 Block ack on write beat 3, TIMEOUT=64 -> timeout_o=1 after 64 cycles, cyc_o=0 next cycle, pass_o=0.
REQ-032 Assert wb_err_i with wb_ack_i on read beat 0 -> bus_err_o=1, err_cnt_o=0, pass_o=0.
REQ-033 Reset at write beat 100, then start -> clean full run, pass_o=1; start_i while busy ignored.
REQ-034 With WB_MEM_CHECKER_BURST_EN -> cti 3'b010 x255 then 3'b111 per phase, cyc continuous per phase, pass_o=1.
